// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage: owns the PC, registers IF/ID, applies branch/jump
// redirects with one delay slot, and stops on a halt address or a misaligned target.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        active,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_if_instr, w_if_instr_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic        r_pend_valid, w_pend_valid_nxt;
  logic [31:0] r_pend_target, w_pend_target_nxt;
  logic        w_apply;
  logic [31:0] w_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_VECTOR;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_valid    <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_if_instr    <= w_if_instr_nxt;
      r_if_pc       <= w_if_pc_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end

  // A redirect latched during a stall takes priority over a fresh one.
  assign w_apply  = r_pend_valid | redirect;
  assign w_target = r_pend_valid ? r_pend_target : redirect_target;

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_instr_nxt    = r_if_instr;
    w_if_pc_nxt       = r_if_pc;
    w_if_valid_nxt    = r_if_valid;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_target_nxt = r_pend_target;
    case (r_state)
      S_FETCH: begin
        if (stall) begin
          if (redirect) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_target_nxt = redirect_target;
          end
        end else if (r_pc == HALT_ADDR) begin
          w_state_nxt      = S_HALTED;
          w_if_valid_nxt   = 1'b0;
          w_pend_valid_nxt = 1'b0;
        end else begin
          // The word captured here is the delay slot when a redirect applies.
          w_if_instr_nxt   = instr_rdata;
          w_if_pc_nxt      = r_pc;
          w_if_valid_nxt   = 1'b1;
          w_pend_valid_nxt = 1'b0;
          if (w_apply) begin
            if (w_target[1:0] != 2'b00) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_pc_nxt = w_target;
            end
          end else begin
            w_pc_nxt = r_pc + 32'd4;
          end
        end
      end
      default: begin
        w_if_valid_nxt   = 1'b0;
        w_pend_valid_nxt = 1'b0;
      end
    endcase
  end

  assign instr_address = r_pc;
  assign if_instr      = r_if_instr;
  assign if_pc         = r_if_pc;
  assign if_valid      = r_if_valid;
  assign active        = (r_state == S_FETCH);
  assign fault         = (r_state == S_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: each vector queues the expected
// post-edge outputs, and a negedge monitor pops and compares them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] instr_address;
  logic [31:0] instr_rdata;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        active;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    string       name;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        act;
    logic        flt;
  } exp_t;

  exp_t q[$];

  fetch_unit #(
    .RESET_VECTOR(32'hBFC00000),
    .HALT_ADDR   (32'h00000000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .instr_address  (instr_address),
    .instr_rdata    (instr_rdata),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .active         (active),
    .fault          (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'hBFC00000: mem = 32'h24020001;
      32'hBFC00004: mem = 32'h24030002;
      default:      mem = {a[15:0], ~a[31:16]};
    endcase
  endfunction

  assign instr_rdata = mem(instr_address);

  task automatic check_out(input string nm, input logic [31:0] ea, input logic ev,
                           input logic [31:0] ep, input logic eact, input logic eflt);
    logic [31:0] ei;
    ei = (ep == 32'h0) ? 32'h0 : mem(ep);
    n_vec++;
    if (instr_address !== ea || if_valid !== ev || if_pc !== ep || if_instr !== ei ||
        active !== eact || fault !== eflt) begin
      n_err++;
      $display("FAIL %s: got addr=%h valid=%b pc=%h instr=%h act=%b flt=%b; want addr=%h valid=%b pc=%h instr=%h act=%b flt=%b",
               nm, instr_address, if_valid, if_pc, if_instr, active, fault,
               ea, ev, ep, ei, eact, eflt);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check_out(e.name, e.addr, e.valid, e.pc, e.act, e.flt);
      end
    end
  end

  // Called at a negedge: drive inputs, queue the outputs expected after the next rising edge.
  task automatic step(input string nm, input logic s, input logic r, input logic [31:0] t,
                      input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                      input logic eact, input logic eflt);
    exp_t e;
    stall           = s;
    redirect        = r;
    redirect_target = t;
    e.due = cyc + 1; e.name = nm; e.addr = ea; e.valid = ev; e.pc = ep;
    e.act = eact; e.flt = eflt;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Asserts reset mid low phase, checks outputs before the next edge, releases at a negedge.
  task automatic do_reset(input string nm);
    #2 rst_n = 1'b0;
    #1 check_out(nm, 32'hBFC00000, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    stall    = 1'b0;
    redirect = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset("reset0");
    step("seq0",      0, 0, 32'h0,        32'hBFC00004, 1, 32'hBFC00000, 1, 0);
    step("seq1",      0, 0, 32'h0,        32'hBFC00008, 1, 32'hBFC00004, 1, 0);
    step("br_slot",   0, 1, 32'hBFBC0004, 32'hBFBC0004, 1, 32'hBFC00008, 1, 0);
    step("br_tgt",    0, 0, 32'h0,        32'hBFBC0008, 1, 32'hBFBC0004, 1, 0);
    step("stall1",    1, 0, 32'h0,        32'hBFBC0008, 1, 32'hBFBC0004, 1, 0);
    step("stall2",    1, 1, 32'hC0000000, 32'hBFBC0008, 1, 32'hBFBC0004, 1, 0);
    step("stall3",    1, 0, 32'h0,        32'hBFBC0008, 1, 32'hBFBC0004, 1, 0);
    step("unstall",   0, 0, 32'h0,        32'hC0000000, 1, 32'hBFBC0008, 1, 0);
    step("pend_tgt",  0, 0, 32'h0,        32'hC0000004, 1, 32'hC0000000, 1, 0);
    step("ovr1",      1, 1, 32'hC0001000, 32'hC0000004, 1, 32'hC0000000, 1, 0);
    step("ovr2",      1, 1, 32'hC0002000, 32'hC0000004, 1, 32'hC0000000, 1, 0);
    step("ovr_apply", 0, 1, 32'hC0003000, 32'hC0002000, 1, 32'hC0000004, 1, 0);
    step("ovr_tgt",   0, 0, 32'h0,        32'hC0002004, 1, 32'hC0002000, 1, 0);
    step("wrap_br",   0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 32'hC0002004, 1, 0);
    step("wrap",      0, 0, 32'h0,        32'h00000000, 1, 32'hFFFFFFFC, 1, 0);
    step("wrap_halt", 0, 0, 32'h0,        32'h00000000, 0, 32'hFFFFFFFC, 0, 0);

    do_reset("reset1");
    step("h_seq",  0, 0, 32'h0, 32'hBFC00004, 1, 32'hBFC00000, 1, 0);
    step("h_slot", 0, 1, 32'h0, 32'h00000000, 1, 32'hBFC00004, 1, 0);
    step("h_halt", 0, 0, 32'h0, 32'h00000000, 0, 32'hBFC00004, 0, 0);
    for (int i = 0; i < 10; i++)
      step("h_hold", (i % 3) == 0, i[0], 32'h100 * i, 32'h0, 0, 32'hBFC00004, 0, 0);

    do_reset("reset2");
    step("m_seq",   0, 0, 32'h0,        32'hBFC00004, 1, 32'hBFC00000, 1, 0);
    step("m_slot",  0, 1, 32'hBFC00012, 32'hBFC00004, 1, 32'hBFC00004, 0, 1);
    step("m_fault", 0, 0, 32'h0,        32'hBFC00004, 0, 32'hBFC00004, 0, 1);
    for (int i = 0; i < 4; i++)
      step("m_hold", i[0], 1, 32'hBFC00010, 32'hBFC00004, 0, 32'hBFC00004, 0, 1);

    do_reset("reset3");
    step("mp_stall", 1, 1, 32'hBFC00002, 32'hBFC00000, 0, 32'h0,        1, 0);
    step("mp_apply", 0, 0, 32'h0,        32'hBFC00000, 1, 32'hBFC00000, 0, 1);
    step("mp_fault", 0, 0, 32'h0,        32'hBFC00000, 0, 32'hBFC00000, 0, 1);

    do_reset("reset4");
    step("a_seq",   1'b0, 1'b0, 32'h0,        32'hBFC00004, 1, 32'hBFC00000, 1, 0);
    step("a_stall", 1'b1, 1'b1, 32'hC0000000, 32'hBFC00004, 1, 32'hBFC00000, 1, 0);
    do_reset("areset");
    step("a_resume", 0, 0, 32'h0, 32'hBFC00004, 1, 32'hBFC00000, 1, 0);
    step("a_seq2",   0, 0, 32'h0, 32'hBFC00008, 1, 32'hBFC00004, 1, 0);

    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
